multicycle_controller: RTL and testbench

//  Main control FSM for the multi-cycle RV32 core. It sequences one shared ALU, one unified memory

---
 rtl/control_defs.sv | 36 +++
 rtl/multicycle_controller.sv | 124 ++++++++++++
 tb/tb_multicycle_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/control_defs.sv
// Shared control encodings for the multi-cycle RV32 core: FSM states, opcodes and
// the mux/ALU select enums driven by the main controller.
package control_defs;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_TRAP     = 4'd9
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLD_PC = 2'b01, SRCA_RS1 = 2'b10} alu_src_a_e;
  typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_e;
  typedef enum logic [1:0] {RES_ALU_REG = 2'b00, RES_DATA = 2'b01, RES_ALU_LIVE = 2'b10} result_src_e;
  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10} imm_src_e;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_sel_e;

endpackage

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32 core: sequences fetch, decode, address
// generation, memory access, execute and writeback around one ALU and one memory port.
module multicycle_controller
  import control_defs::*;
#(
  parameter bit TRAP_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal_instr,
  output logic       busy
);

  state_e r_state;
  state_e w_next_state;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXECUTER;
          OP_BEQ:       w_next_state = S_BEQ;
          default:      w_next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
      S_EXECUTER: w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BEQ:      w_next_state = S_FETCH;
      S_TRAP:     if (!TRAP_STICKY) w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Reset overrides the decode so nothing is written while the FSM is being re-homed.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    imm_src       = IMM_I;
    result_src    = RES_ALU_REG;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;
    busy          = 1'b0;
    if (!reset) begin
      busy = (r_state != S_FETCH);
      case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU_LIVE;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLD_PC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (op == OP_LW) ? IMM_I : IMM_S;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECUTER: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB:    reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_SUB;
          pc_write  = zero;
        end
        S_TRAP:     illegal_instr = 1'b1;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle control vectors for a
// sticky-trap and a non-sticky-trap instance driven by the same stimulus.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [6:0] op = 7'b0000011;

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] BQ = 7'b1100011, BAD = 7'b1111111;

  // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,illegal,busy}_a_b_imm_res_aluop
  localparam logic [17:0] E_RST      = 18'b00000000_00_00_00_00_00;
  localparam logic [17:0] E_FETCH_W  = 18'b10000000_00_10_00_10_00;
  localparam logic [17:0] E_FETCH_R  = 18'b10011000_00_10_00_10_00;
  localparam logic [17:0] E_DECODE   = 18'b00000001_01_01_10_00_00;
  localparam logic [17:0] E_MEMADR_L = 18'b00000001_10_01_00_00_00;
  localparam logic [17:0] E_MEMADR_S = 18'b00000001_10_01_01_00_00;
  localparam logic [17:0] E_MEMREAD  = 18'b10100001_00_00_00_00_00;
  localparam logic [17:0] E_MEMWB    = 18'b00000101_00_00_00_01_00;
  localparam logic [17:0] E_MEMWR    = 18'b11100001_00_00_00_00_00;
  localparam logic [17:0] E_EXEC     = 18'b00000001_10_00_00_00_10;
  localparam logic [17:0] E_ALUWB    = 18'b00000101_00_00_00_00_00;
  localparam logic [17:0] E_BEQ_T    = 18'b00001001_10_00_00_00_01;
  localparam logic [17:0] E_BEQ_N    = 18'b00000001_10_00_00_00_01;
  localparam logic [17:0] E_TRAP     = 18'b00000011_00_00_00_00_00;

  logic       s_mem_req, s_mem_write, s_adr_src, s_ir_write, s_pc_write, s_reg_write;
  logic       s_illegal, s_busy;
  logic [1:0] s_a, s_b, s_imm, s_res, s_aluop;
  logic       n_mem_req, n_mem_write, n_adr_src, n_ir_write, n_pc_write, n_reg_write;
  logic       n_illegal, n_busy;
  logic [1:0] n_a, n_b, n_imm, n_res, n_aluop;
  logic [17:0] s_vec, n_vec;

  assign s_vec = {s_mem_req, s_mem_write, s_adr_src, s_ir_write, s_pc_write, s_reg_write,
                  s_illegal, s_busy, s_a, s_b, s_imm, s_res, s_aluop};
  assign n_vec = {n_mem_req, n_mem_write, n_adr_src, n_ir_write, n_pc_write, n_reg_write,
                  n_illegal, n_busy, n_a, n_b, n_imm, n_res, n_aluop};

  multicycle_controller #(.TRAP_STICKY(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .mem_write(s_mem_write), .adr_src(s_adr_src),
    .ir_write(s_ir_write), .pc_write(s_pc_write), .reg_write(s_reg_write),
    .alu_src_a(s_a), .alu_src_b(s_b), .imm_src(s_imm), .result_src(s_res),
    .alu_op(s_aluop), .illegal_instr(s_illegal), .busy(s_busy)
  );

  multicycle_controller #(.TRAP_STICKY(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .mem_write(n_mem_write), .adr_src(n_adr_src),
    .ir_write(n_ir_write), .pc_write(n_pc_write), .reg_write(n_reg_write),
    .alu_src_a(n_a), .alu_src_b(n_b), .imm_src(n_imm), .result_src(n_res),
    .alu_op(n_aluop), .illegal_instr(n_illegal), .busy(n_busy)
  );

  string       name_q[$];
  logic [17:0] es_q[$];
  logic [17:0] en_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string nm, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", nm, got, exp);
    end else begin
      $display("ok   %s: %b", nm, got);
    end
  endtask

  // Apply inputs just after the edge and queue the vector expected for that cycle.
  task automatic step2(input string nm, input logic rst, input logic mr, input logic z,
                       input logic [6:0] o, input logic [17:0] es, input logic [17:0] en);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = mr;
    zero      = z;
    op        = o;
    name_q.push_back(nm);
    es_q.push_back(es);
    en_q.push_back(en);
  endtask

  task automatic step(input string nm, input logic rst, input logic mr, input logic z,
                      input logic [6:0] o, input logic [17:0] e);
    step2(nm, rst, mr, z, o, e, e);
  endtask

  initial begin : monitor
    string       nm;
    logic [17:0] es, en;
    forever begin
      @(negedge clk);
      if (name_q.size() > 0) begin
        nm = name_q.pop_front();
        es = es_q.pop_front();
        en = en_q.pop_front();
        check({nm, "/sticky"}, s_vec, es);
        check({nm, "/nonsticky"}, n_vec, en);
      end
    end
  end

  initial begin : stimulus
    step("rst", 1, 0, 0, LW, E_RST);
    step("rst", 1, 0, 0, LW, E_RST);
    // Reset arriving while a load waits in MEMREAD
    step("lw0_fetch",   0, 1, 0, LW, E_FETCH_R);
    step("lw0_decode",  0, 1, 0, LW, E_DECODE);
    step("lw0_memadr",  0, 1, 0, LW, E_MEMADR_L);
    step("lw0_memread", 0, 0, 0, LW, E_MEMREAD);
    for (int i = 0; i < 3; i++) step("rst_mid_memread", 1, 0, 0, LW, E_RST);
    step("post_rst_fetch_wait", 0, 0, 0, LW, E_FETCH_W);
    // Load with mem_ready high
    step("lw_fetch",   0, 1, 0, LW, E_FETCH_R);
    step("lw_decode",  0, 1, 0, LW, E_DECODE);
    step("lw_memadr",  0, 1, 0, LW, E_MEMADR_L);
    step("lw_memread", 0, 1, 0, LW, E_MEMREAD);
    step("lw_memwb",   0, 1, 0, LW, E_MEMWB);
    // Store stalled two cycles in MEMWRITE
    step("sw_fetch",   0, 1, 0, SW, E_FETCH_R);
    step("sw_decode",  0, 1, 0, SW, E_DECODE);
    step("sw_memadr",  0, 1, 0, SW, E_MEMADR_S);
    step("sw_memwr_wait1", 0, 0, 0, SW, E_MEMWR);
    step("sw_memwr_wait2", 0, 0, 0, SW, E_MEMWR);
    step("sw_memwr_done",  0, 1, 0, SW, E_MEMWR);
    // R-type, preceded by one stalled fetch cycle
    step("r_fetch_wait", 0, 0, 0, RT, E_FETCH_W);
    step("r_fetch",    0, 1, 0, RT, E_FETCH_R);
    step("r_decode",   0, 1, 0, RT, E_DECODE);
    step("r_exec",     0, 1, 0, RT, E_EXEC);
    step("r_aluwb",    0, 1, 0, RT, E_ALUWB);
    // Branch taken then not taken
    step("beq1_fetch",  0, 1, 0, BQ, E_FETCH_R);
    step("beq1_decode", 0, 1, 0, BQ, E_DECODE);
    step("beq1_taken",  0, 1, 1, BQ, E_BEQ_T);
    step("beq0_fetch",  0, 1, 1, BQ, E_FETCH_R);
    step("beq0_decode", 0, 1, 1, BQ, E_DECODE);
    step("beq0_nottaken", 0, 1, 0, BQ, E_BEQ_N);
    // Illegal opcode: sticky instance parks, non-sticky instance keeps re-fetching
    step("bad_fetch",  0, 1, 0, BAD, E_FETCH_R);
    step("bad_decode", 0, 1, 0, BAD, E_DECODE);
    for (int i = 0; i < 10; i++) begin
      step2("trap", 0, 1, 0, BAD, E_TRAP,
            (i % 3 == 0) ? E_TRAP : ((i % 3 == 1) ? E_FETCH_R : E_DECODE));
    end
    @(posedge clk);
    #1;
    checks++;
    if (name_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", name_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
